stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel registered stream multiplexer with per-channel valid/ready handshakes and a one-word output register. It runs in one of two modes: software-steered select (`sel_in`) or fair round-robin arbitration across requesting channels. It is the successor to the 4:1 combinational data mux and sits between several producer streams and a single downstream consumer. It sustains one word per cycle with one cycle of latency.

## Interface

Parameters:
- `WIDTH`, default 4: bits per channel word.
- `CHANNELS`, default 4: number of input channels; must be ≥ 2.
- `SEL_W`: localparam equal to $clog2(CHANNELS); not overridable.

Ports:
- `clk_in`, input, 1: single clock; all state updates on the rising edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `data_in`, input, CHANNELS*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- `valid_in`, input, CHANNELS: per-channel word-valid.
- `ready_out`, output, CHANNELS: per-channel accept; one-hot or zero.
- `sel_in`, input, SEL_W: channel to pass in mode 0; ignored in mode 1.
- `mode_in`, input, 1: 0 = select mode, 1 = round-robin mode.
- `y_out`, output, WIDTH: registered output word.
- `valid_out`, output, 1: `y_out` holds an unconsumed word.
- `ready_in`, input, 1: downstream accepts `y_out` this cycle.
- `grant_out`, output, SEL_W: channel index that sourced the current `y_out`.

## Operation

- **States.** Two states, implied by `valid_out`:
  - EMPTY (`valid_out` = 0).
  - FULL (`valid_out` = 1).
- **free.** `free` = !`valid_out` | `ready_in`. The register can load this cycle.
- **Candidate, mode 0.** The candidate is c = `sel_in` when `sel_in` < CHANNELS and `valid_in[c]` = 1. Otherwise there is no candidate; out-of-range `sel_in` selects nothing.
- **Candidate, mode 1.** The candidate is the first channel with `valid_in` = 1, searching from `ptr`+1 upward and wrapping modulo CHANNELS through `ptr` itself.
- **ptr.** Internal SEL_W-bit register holding the last granted channel.
- **ready_out.** `ready_out[c]` = `free` & (c is the candidate). It is combinational from `valid_in`, `sel_in`, `mode_in`, `ready_in`, `valid_out` and `ptr`. At most one bit is set.
- **Transfer on candidate c while free.**
  - `y_out` <= channel c data.
  - `valid_out` <= 1.
  - `grant_out` <= c.
  - `ptr` <= c. This happens in both modes, so round-robin resumes after the last served channel.
- **Free with no candidate.** `valid_out` <= 0. `y_out`, `grant_out` and `ptr` hold.
- **Not free** (FULL and !`ready_in`). All registers hold and every `ready_out` bit is 0. The held word must stay stable until consumed.
- **Mode or select change.** A change of `mode_in` or `sel_in` affects only the next selection. It never alters a word already in the output register.
- **Width rules.** Data passes unmodified. `ptr` increment wraps from CHANNELS-1 to 0, which also holds when CHANNELS is not a power of two.

## Timing

- **Reset values.** While `rst_in` = 1 at an edge:
  - `y_out` = 0.
  - `valid_out` = 0.
  - `grant_out` = 0.
  - `ptr` = CHANNELS-1, so the first round-robin search starts at channel 0.
- **ready_out during reset.** `ready_out` is 0 in any cycle where `rst_in` = 1.
- **Reset mid-operation.** A held word is discarded. No handshake completes in that cycle.
- **Latency.** One cycle from input handshake to `valid_out`.
- **Throughput.** One word per cycle while `ready_in` stays 1.
- **Simultaneous events.** Consume and load in the same cycle (FULL, `ready_in` = 1, candidate present) leaves the block FULL with the new word; there is no bubble.
- **Backpressure.** `ready_in` low for any number of cycles holds `y_out`, `valid_out` and `grant_out` unchanged.
- **Input valid.** `valid_in` may drop without a handshake; this block places no requirement on the producer.

## Test plan

1. **Reset.** Assert `rst_in` with all `valid_in` = 1111. Require `valid_out` = 0, `y_out` = 0, `grant_out` = 0 and `ready_out` = 0000. Deassert reset in mode 1 with `ready_in` = 1: the first grant is channel 0.
2. **Select mode.** `mode_in` = 0, `sel_in` = 2, `data_in` = {4'hD, 4'hC, 4'hB, 4'hA}, `valid_in` = 0100, `ready_in` = 1.
   - Require `ready_out` = 0100 and, next cycle, `y_out` = C, `grant_out` = 2, `valid_out` = 1.
   - Then set `valid_in` = 1011 with `sel_in` still 2: require `ready_out` = 0000 and `valid_out` falling to 0.
3. **Round-robin fairness.** `mode_in` = 1, all `valid_in` = 1111 held, `ready_in` = 1.
   - Require grants 0, 1, 2, 3, 0, … on consecutive cycles.
   - Then set `valid_in` = 1010: require grants to alternate 1, 3, 1, 3.
4. **Backpressure.** Word 5 is granted from channel 1, then `ready_in` = 0 for 3 cycles.
   - Require `y_out` = 5, `grant_out` = 1, `valid_out` = 1 stable and `ready_out` = 0000 throughout.
   - On `ready_in` = 1, the next candidate loads in that same cycle.
5. **Boundaries.**
   - With CHANNELS = 3, mode 0 and `sel_in` = 3: require no `ready_out` and no load.
   - With CHANNELS = 3, mode 1 and `ptr` = 2: require the next search to wrap to channel 0.
6. **Mid-stream reset.** Assert `rst_in` while FULL with `ready_in` = 0. Require `valid_out` = 0 next cycle, the word to be lost, and arbitration to restart at channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with per-channel valid/ready handshakes.
// Selection is either software-steered (sel_in) or round-robin from the last grant.
module stream_mux_rr #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_out,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode_in,
  output logic [WIDTH-1:0]          y_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [SEL_W-1:0]          grant_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] grant_d;
  logic [WIDTH-1:0] y_d;

  logic             free_c;
  logic             cand_vld;
  logic [SEL_W-1:0] cand_idx;
  logic [WIDTH-1:0] cand_data;
  int unsigned      off;
  int unsigned      best_off;
  logic             take;

  assign valid_out = (state_q == FULL);
  assign free_c    = (state_q == EMPTY) || ready_in;

  // Candidate pick; in round-robin, off is the distance past ptr (0 means ptr+1).
  always_comb begin
    cand_vld  = 1'b0;
    cand_idx  = '0;
    cand_data = '0;
    best_off  = '0;
    off       = '0;
    take      = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      off = (c + CHANNELS - 1 - 32'(ptr_q)) % CHANNELS;
      if (!mode_in) begin
        take = valid_in[c] && (sel_in == SEL_W'(c));
      end else begin
        take = valid_in[c] && (!cand_vld || (off < best_off));
      end
      if (take) begin
        cand_vld  = 1'b1;
        cand_idx  = SEL_W'(c);
        cand_data = data_in[c*WIDTH +: WIDTH];
        best_off  = off;
      end
    end
  end

  // Accept strobe to the chosen producer; suppressed while in reset.
  always_comb begin
    ready_out = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ready_out[c] = !rst_in && free_c && cand_vld && (cand_idx == SEL_W'(c));
    end
  end

  // Next-state and register payload.
  always_comb begin
    state_d = state_q;
    y_d     = y_out;
    grant_d = grant_out;
    ptr_d   = ptr_q;
    if (free_c) begin
      if (cand_vld) begin
        state_d = FULL;
        y_d     = cand_data;
        grant_d = cand_idx;
        ptr_d   = cand_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= EMPTY;
      y_out     <= '0;
      grant_out <= '0;
      ptr_q     <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q   <= state_d;
      y_out     <= y_d;
      grant_out <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main scenarios
// and a 3-channel instance for the non-power-of-two boundaries.
module tb_stream_mux_rr;

  logic        clk_in = 1'b0;
  logic        rst_in;

  logic [15:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic [1:0]  sel4;
  logic        mode4;
  logic [3:0]  y4;
  logic        vout4;
  logic        rdy_in4;
  logic [1:0]  grant4;

  logic [11:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [3:0]  y3;
  logic        vout3;
  logic        rdy_in3;
  logic [1:0]  grant3;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4)) u4 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data4), .valid_in(valid4),
    .ready_out(ready4), .sel_in(sel4), .mode_in(mode4), .y_out(y4),
    .valid_out(vout4), .ready_in(rdy_in4), .grant_out(grant4)
  );

  stream_mux_rr #(.WIDTH(4), .CHANNELS(3)) u3 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data3), .valid_in(valid3),
    .ready_out(ready3), .sel_in(sel3), .mode_in(mode3), .y_out(y3),
    .valid_out(vout3), .ready_in(rdy_in3), .grant_out(grant3)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in  = 1'b1;
    data4   = {4'hD, 4'hC, 4'hB, 4'hA};
    valid4  = 4'b1111;
    mode4   = 1'b1;
    sel4    = 2'd0;
    rdy_in4 = 1'b1;
    data3   = 12'h321;
    valid3  = 3'b000;
    mode3   = 1'b0;
    sel3    = 2'd0;
    rdy_in3 = 1'b1;
    tick();
    tick();
    checks++;
    if (vout4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vout4); end
    checks++;
    if (y4 !== 4'h0) begin errors++; $display("FAIL reset_y got %h exp 0", y4); end
    checks++;
    if (grant4 !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant4); end
    checks++;
    if (ready4 !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready4); end
    rst_in = 1'b0;
    #1;
    checks++;
    if (ready4 !== 4'b0001) begin errors++; $display("FAIL reset_first_ready got %b exp 0001", ready4); end
    tick();
    checks++;
    if (grant4 !== 2'd0 || y4 !== 4'hA || vout4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got g=%0d y=%h v=%b exp g=0 y=a v=1", grant4, y4, vout4);
    end
  endtask

  task automatic test_select();
    mode4   = 1'b0;
    sel4    = 2'd2;
    valid4  = 4'b0100;
    rdy_in4 = 1'b1;
    #1;
    checks++;
    if (ready4 !== 4'b0100) begin errors++; $display("FAIL sel_ready got %b exp 0100", ready4); end
    tick();
    checks++;
    if (y4 !== 4'hC || grant4 !== 2'd2 || vout4 !== 1'b1) begin
      errors++;
      $display("FAIL sel_load got y=%h g=%0d v=%b exp y=c g=2 v=1", y4, grant4, vout4);
    end
    valid4 = 4'b1011;
    #1;
    checks++;
    if (ready4 !== 4'b0000) begin errors++; $display("FAIL sel_novalid_ready got %b exp 0000", ready4); end
    tick();
    checks++;
    if (vout4 !== 1'b0 || y4 !== 4'hC || grant4 !== 2'd2) begin
      errors++;
      $display("FAIL sel_drain got v=%b y=%h g=%0d exp v=0 y=c g=2", vout4, y4, grant4);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] words [4];
    logic [1:0] alt [4];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    alt[0] = 2'd1; alt[1] = 2'd3; alt[2] = 2'd1; alt[3] = 2'd3;
    rst_in = 1'b1;
    tick();
    rst_in  = 1'b0;
    mode4   = 1'b1;
    valid4  = 4'b1111;
    rdy_in4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (grant4 !== 2'(k % 4) || y4 !== words[k % 4] || vout4 !== 1'b1) begin
        errors++;
        $display("FAIL rr_all[%0d] got g=%0d y=%h exp g=%0d y=%h", k, grant4, y4, k % 4, words[k % 4]);
      end
    end
    valid4 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (grant4 !== alt[k]) begin
        errors++;
        $display("FAIL rr_alt[%0d] got g=%0d exp g=%0d", k, grant4, alt[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    data4   = {4'hD, 4'hC, 4'h5, 4'hA};
    mode4   = 1'b1;
    valid4  = 4'b0010;
    rdy_in4 = 1'b1;
    tick();
    checks++;
    if (y4 !== 4'h5 || grant4 !== 2'd1) begin
      errors++;
      $display("FAIL bp_load got y=%h g=%0d exp y=5 g=1", y4, grant4);
    end
    rdy_in4 = 1'b0;
    valid4  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ready4 !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, ready4); end
      tick();
      checks++;
      if (y4 !== 4'h5 || grant4 !== 2'd1 || vout4 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got y=%h g=%0d v=%b exp y=5 g=1 v=1", k, y4, grant4, vout4);
      end
    end
    rdy_in4 = 1'b1;
    #1;
    checks++;
    if (ready4 !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", ready4); end
    tick();
    checks++;
    if (y4 !== 4'hC || grant4 !== 2'd2 || vout4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_load got y=%h g=%0d v=%b exp y=c g=2 v=1", y4, grant4, vout4);
    end
  endtask

  task automatic test_boundary();
    logic [1:0] seq [3];
    logic [3:0] wv  [3];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd0;
    wv[0]  = 4'h2; wv[1]  = 4'h3; wv[2]  = 4'h1;
    mode3   = 1'b0;
    sel3    = 2'd3;
    valid3  = 3'b111;
    rdy_in3 = 1'b1;
    #1;
    checks++;
    if (ready3 !== 3'b000) begin errors++; $display("FAIL bnd_sel3_ready got %b exp 000", ready3); end
    tick();
    checks++;
    if (vout3 !== 1'b0 || y3 !== 4'h0) begin
      errors++;
      $display("FAIL bnd_sel3_load got v=%b y=%h exp v=0 y=0", vout3, y3);
    end
    sel3 = 2'd2;
    tick();
    checks++;
    if (grant3 !== 2'd2 || y3 !== 4'h3) begin
      errors++;
      $display("FAIL bnd_sel2 got g=%0d y=%h exp g=2 y=3", grant3, y3);
    end
    mode3 = 1'b1;
    #1;
    checks++;
    if (ready3 !== 3'b001) begin errors++; $display("FAIL bnd_wrap_ready got %b exp 001", ready3); end
    tick();
    checks++;
    if (grant3 !== 2'd0 || y3 !== 4'h1) begin
      errors++;
      $display("FAIL bnd_wrap got g=%0d y=%h exp g=0 y=1", grant3, y3);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (grant3 !== seq[k] || y3 !== wv[k]) begin
        errors++;
        $display("FAIL bnd_rr3[%0d] got g=%0d y=%h exp g=%0d y=%h", k, grant3, y3, seq[k], wv[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    data4   = {4'hD, 4'hC, 4'hB, 4'hA};
    mode4   = 1'b1;
    valid4  = 4'b1000;
    rdy_in4 = 1'b1;
    tick();
    rdy_in4 = 1'b0;
    valid4  = 4'b1111;
    tick();
    checks++;
    if (vout4 !== 1'b1 || y4 !== 4'hD) begin
      errors++;
      $display("FAIL mid_full got v=%b y=%h exp v=1 y=d", vout4, y4);
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if (ready4 !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", ready4); end
    tick();
    checks++;
    if (vout4 !== 1'b0 || y4 !== 4'h0 || grant4 !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst_clear got v=%b y=%h g=%0d exp v=0 y=0 g=0", vout4, y4, grant4);
    end
    rst_in  = 1'b0;
    rdy_in4 = 1'b1;
    #1;
    checks++;
    if (ready4 !== 4'b0001) begin errors++; $display("FAIL mid_restart_ready got %b exp 0001", ready4); end
    tick();
    checks++;
    if (grant4 !== 2'd0 || y4 !== 4'hA || vout4 !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got g=%0d y=%h v=%b exp g=0 y=a v=1", grant4, y4, vout4);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
